// File: rtl/lfsr_sched_pkg.sv
// Shared arbiter types: scheduler FSM encoding and a cyclic round-robin pick.
package lfsr_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STEP    = 2'd1,
    S_DELIVER = 2'd2
  } state_t;

  localparam int RR_MAX = 32;
  localparam int RR_IW  = 5;

  typedef struct packed {
    logic             found;
    logic [RR_IW-1:0] idx;
  } rr_pick_t;

  // First set bit of req at or after ptr, wrapping at n (n <= RR_MAX, ptr < n).
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                       input logic [RR_IW-1:0]  ptr,
                                       input int                n);
    rr_pick_t res;
    int       pos;
    res = '0;
    for (int i = 0; i < RR_MAX; i++) begin
      pos = int'(ptr) + i;
      if (pos >= n) begin
        pos = pos - n;
      end
      if (!res.found && (i < n) && req[pos[RR_IW-1:0]]) begin
        res.found = 1'b1;
        res.idx   = pos[RR_IW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/lfsr3.sv
// Galois XNOR LFSR, shifting right; a zero LSB injects the tap mask.
// Reset is synchronous, so the state is 0 after any clock edge with i_reset high.
module lfsr3 #(
  parameter int           W = 16,
  parameter logic [W-1:0] K = 16'hb400
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_step,
  output logic [W-1:0] o_state
);

  logic [W-1:0] r_state;

  // LFSR state register with synchronous clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= '0;
    end else if (i_step) begin
      r_state <= {1'b0, r_state[W-1:1]} ^ ({W{~r_state[0]}} & K);
    end else begin
      r_state <= r_state;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/lfsr_sched.sv
// Round-robin scheduler sharing one lfsr3 among N requesters: each grant steps
// the LFSR GAP times, then strobes one word to the granted requester.
module lfsr_sched
  import lfsr_sched_pkg::*;
#(
  parameter int           N   = 4,
  parameter int           W   = 16,
  parameter logic [W-1:0] K   = 16'hb400,
  parameter int           GAP = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [N-1:0] i_req,
  input  logic         i_freerun,
  output logic [N-1:0] o_gnt,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_busy
);

  localparam int CW = $clog2(GAP + 1);

  state_t              r_state;
  logic [RR_IW-1:0]    r_ptr;
  logic [RR_IW-1:0]    r_idx;
  logic [CW-1:0]       r_cnt;
  logic [N-1:0]        r_gnt;
  logic                r_valid;
  logic [W-1:0]        r_data;
  logic                r_busy;

  logic [RR_MAX-1:0]   w_req_ext;
  rr_pick_t            w_pick;
  logic [N-1:0]        w_onehot;
  logic [RR_IW-1:0]    w_idx_next;
  logic                w_step;
  logic [W-1:0]        w_lfsr;

  // Arbitration and LFSR step control; the step is suppressed during reset.
  always_comb begin
    w_req_ext  = {{(RR_MAX-N){1'b0}}, i_req};
    w_pick     = rr_pick(w_req_ext, r_ptr, N);
    w_onehot   = {{(N-1){1'b0}}, 1'b1} << w_pick.idx;
    w_idx_next = (r_idx == RR_IW'(N-1)) ? {RR_IW{1'b0}} : r_idx + RR_IW'(1);
    case (r_state)
      S_IDLE:    w_step = i_freerun & ~(|i_req);
      S_STEP:    w_step = 1'b1;
      S_DELIVER: w_step = 1'b0;
      default:   w_step = 1'b0;
    endcase
    if (i_reset) begin
      w_step = 1'b0;
    end else begin
      w_step = w_step;
    end
  end

  // Scheduler FSM; o_gnt/o_busy stay up through the o_valid cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick.found) begin
            r_gnt   <= w_onehot;
            r_idx   <= w_pick.idx;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_STEP;
          end else begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
          end
        end
        S_STEP: begin
          if (!w_req_ext[r_idx]) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= w_idx_next;
            r_state <= S_IDLE;
          end else if (r_cnt == CW'(GAP - 1)) begin
            r_state <= S_DELIVER;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        S_DELIVER: begin
          r_valid <= 1'b1;
          r_data  <= w_lfsr;
          r_ptr   <= w_idx_next;
          r_state <= S_IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  lfsr3 #(
    .W (W),
    .K (K)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_step  (w_step),
    .o_state (w_lfsr)
  );

  assign o_gnt   = r_gnt;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_busy  = r_busy;

endmodule
